maze_bitmap_ram: RTL and testbench

Double-buffered, parametrised maze bitmap store for the tank game. Software writes over Avalon-MM into a back bank while the pixel pipeline reads a front bank. The pixel side returns the current cell and its four neighbours for wall collision and colour mapping. Banks swap only on a frame boundary, and a hardware clear engine wipes the back bank without a software loop.

---
 rtl/maze_pkg.sv | 25 ++
 rtl/maze_bitmap_ram_neighbour_addr.sv | 64 ++++++
 rtl/maze_bitmap_ram.sv | 167 ++++++++++++++++
 tb/tb_maze_bitmap_ram.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared constants for the maze bitmap store: CTRL/STATUS bit positions,
// neighbour position indices and the clear-engine state type.
package maze_pkg;

  localparam int CTRL_SWAP  = 0;
  localparam int CTRL_CLEAR = 1;

  localparam int STAT_PENDING = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_FRONT   = 2;
  localparam int STAT_READY   = 3;

  localparam int NPOS      = 5;
  localparam int POS_CUR   = 0;
  localparam int POS_UP    = 1;
  localparam int POS_DOWN  = 2;
  localparam int POS_LEFT  = 3;
  localparam int POS_RIGHT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/maze_bitmap_ram_neighbour_addr.sv
// Maps a pixel to storage word/bit indices for the current cell and its four
// neighbours, plus per-neighbour "outside the maze" flags and an out-of-range flag.
module maze_neighbour_addr
  import maze_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int ROW_WORDS  = 5,
  parameter int ROWS       = 120,
  parameter int CELL_SHIFT = 2,
  parameter int WADDR_W    = $clog2(ROW_WORDS * ROWS),
  parameter int BIT_W      = $clog2(WORD_W)
) (
  input  logic [9:0]                      draw_x_i,
  input  logic [9:0]                      draw_y_i,
  output logic [NPOS-1:0][WADDR_W-1:0]    word_o,
  output logic [NPOS-1:0][BIT_W-1:0]      bit_o,
  output logic [NPOS-1:0]                 edge_o,
  output logic                            oor_o
);

  localparam int unsigned COLS = ROW_WORDS * WORD_W;

  logic [31:0] cx, cy;
  logic [31:0] px [NPOS];
  logic [31:0] py [NPOS];

  function automatic logic [WADDR_W-1:0] word_of(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] w;
    w = y * ROW_WORDS + (x >> BIT_W);
    return w[WADDR_W-1:0];
  endfunction

  always_comb begin
    cx    = 32'(draw_x_i >> CELL_SHIFT);
    cy    = 32'(draw_y_i >> CELL_SHIFT);
    oor_o = (cx >= COLS) || (cy >= ROWS);
    // Clamp to cell 0 so indices stay inside the array when the pixel is off-maze.
    if (oor_o) begin
      cx = '0;
      cy = '0;
    end

    edge_o            = '0;
    edge_o[POS_UP]    = (cy == 0);
    edge_o[POS_DOWN]  = (cy == ROWS - 1);
    edge_o[POS_LEFT]  = (cx == 0);
    edge_o[POS_RIGHT] = (cx == COLS - 1);

    for (int p = 0; p < NPOS; p++) begin
      px[p] = cx;
      py[p] = cy;
    end
    if (!edge_o[POS_UP])    py[POS_UP]    = cy - 32'd1;
    if (!edge_o[POS_DOWN])  py[POS_DOWN]  = cy + 32'd1;
    if (!edge_o[POS_LEFT])  px[POS_LEFT]  = cx - 32'd1;
    if (!edge_o[POS_RIGHT]) px[POS_RIGHT] = cx + 32'd1;

    for (int p = 0; p < NPOS; p++) begin
      word_o[p] = word_of(px[p], py[p]);
      bit_o[p]  = ~px[p][BIT_W-1:0];
    end
  end

endmodule

// File: rtl/maze_bitmap_ram.sv
// Double-buffered maze bitmap: Avalon-MM access to the back bank, pixel lookup on the front bank.
// Clear FSM:  IDLE | no clear running  ;  CLEAR | zeroing back-bank word cnt_q, one per cycle
module maze_bitmap_ram
  import maze_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int ROW_WORDS  = 5,
  parameter int ROWS       = 120,
  parameter int CELL_SHIFT = 2,
  parameter int ADDR_W     = 10
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  AVL_READ,
  input  logic                  AVL_WRITE,
  input  logic                  AVL_CS,
  input  logic [WORD_W/8-1:0]   AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]     AVL_ADDR,
  input  logic [WORD_W-1:0]     AVL_WRITEDATA,
  output logic [WORD_W-1:0]     AVL_READDATA,
  input  logic                  FRAME_START,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  output logic                  cell_cur,
  output logic                  cell_up,
  output logic                  cell_down,
  output logic                  cell_left,
  output logic                  cell_right,
  output logic                  maze_ready
);

  localparam int DEPTH   = ROW_WORDS * ROWS;
  localparam int WADDR_W = $clog2(DEPTH);
  localparam int BIT_W   = $clog2(WORD_W);
  localparam int NBYTES  = WORD_W / 8;
  localparam logic [ADDR_W-1:0]  CTRL_ADDR = ADDR_W'(DEPTH);
  localparam logic [WADDR_W-1:0] LAST_WORD = WADDR_W'(DEPTH - 1);

  logic [WORD_W-1:0] mem_q [2][DEPTH];

  clr_state_e         state_q;
  logic [WADDR_W-1:0] cnt_q;
  logic               front_q, pending_q, ready_q;
  logic [WORD_W-1:0]  rdata_q, rdata_d;
  logic [NPOS-1:0]    cells_q, cells_d;

  logic               busy, back, data_hit, ctrl_hit;
  logic               wr_data, wr_ctrl, clear_start, do_swap, rd_en;
  logic [WADDR_W-1:0] data_addr;

  logic [NPOS-1:0][WADDR_W-1:0] pix_word;
  logic [NPOS-1:0][BIT_W-1:0]   pix_bit;
  logic [NPOS-1:0]              pix_edge;
  logic                         pix_oor;

  maze_neighbour_addr #(
    .WORD_W     (WORD_W),
    .ROW_WORDS  (ROW_WORDS),
    .ROWS       (ROWS),
    .CELL_SHIFT (CELL_SHIFT),
    .WADDR_W    (WADDR_W),
    .BIT_W      (BIT_W)
  ) u_addr (
    .draw_x_i (DrawX),
    .draw_y_i (DrawY),
    .word_o   (pix_word),
    .bit_o    (pix_bit),
    .edge_o   (pix_edge),
    .oor_o    (pix_oor)
  );

  assign busy        = (state_q == CLEAR);
  assign back        = ~front_q;
  assign data_hit    = (AVL_ADDR < CTRL_ADDR);
  assign ctrl_hit    = (AVL_ADDR == CTRL_ADDR);
  assign data_addr   = AVL_ADDR[WADDR_W-1:0];
  assign rd_en       = AVL_CS & AVL_READ;
  assign wr_data     = AVL_CS & AVL_WRITE & data_hit & ~busy;
  assign wr_ctrl     = AVL_CS & AVL_WRITE & ctrl_hit & AVL_BYTE_EN[0];
  assign clear_start = wr_ctrl & AVL_WRITEDATA[CTRL_CLEAR] & ~busy;
  // A clear starting this cycle targets the current back bank, so no swap may land with it.
  assign do_swap     = FRAME_START & pending_q & ~busy & ~clear_start;

  always_ff @(posedge CLK) begin
    if (busy) begin
      mem_q[back][cnt_q] <= '0;
    end else if (wr_data) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (AVL_BYTE_EN[b]) mem_q[back][data_addr][b*8 +: 8] <= AVL_WRITEDATA[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (data_hit) begin
      rdata_d = mem_q[back][data_addr];
    end else if (ctrl_hit) begin
      rdata_d[STAT_PENDING] = pending_q;
      rdata_d[STAT_BUSY]    = busy;
      rdata_d[STAT_FRONT]   = front_q;
      rdata_d[STAT_READY]   = ready_q;
    end
  end

  always_comb begin
    cells_d = '0;
    if (ready_q) begin
      if (pix_oor) begin
        cells_d = '1;
      end else begin
        for (int p = 0; p < NPOS; p++) begin
          cells_d[p] = pix_edge[p] | mem_q[front_q][pix_word[p]][pix_bit[p]];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      front_q   <= 1'b0;
      pending_q <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      cells_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_start) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          if (cnt_q == LAST_WORD) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase

      if (wr_ctrl && AVL_WRITEDATA[CTRL_SWAP]) pending_q <= 1'b1;
      else if (do_swap)                        pending_q <= 1'b0;

      if (do_swap) begin
        front_q <= ~front_q;
        ready_q <= 1'b1;
      end

      if (rd_en) rdata_q <= rdata_d;
      cells_q <= cells_d;
    end
  end

  assign AVL_READDATA = rdata_q;
  assign maze_ready   = ready_q;
  assign cell_cur     = cells_q[POS_CUR];
  assign cell_up      = cells_q[POS_UP];
  assign cell_down    = cells_q[POS_DOWN];
  assign cell_left    = cells_q[POS_LEFT];
  assign cell_right   = cells_q[POS_RIGHT];

endmodule

// File: tb/tb_maze_bitmap_ram.sv
// Bench for maze_bitmap_ram: directed steps plus random traffic against a
// cell-grid reference model of both banks, swap and clear behaviour.
module tb_maze_bitmap_ram;

  localparam int WORD_W = 32, ROW_WORDS = 5, ROWS = 120, CELL_SHIFT = 2, ADDR_W = 10;
  localparam int DEPTH = ROW_WORDS * ROWS;
  localparam int COLS  = ROW_WORDS * WORD_W;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              AVL_READ, AVL_WRITE, AVL_CS;
  logic [3:0]        AVL_BYTE_EN;
  logic [ADDR_W-1:0] AVL_ADDR;
  logic [31:0]       AVL_WRITEDATA, AVL_READDATA;
  logic              FRAME_START;
  logic [9:0]        DrawX, DrawY;
  logic              cell_cur, cell_up, cell_down, cell_left, cell_right, maze_ready;
  logic [4:0]        dut_cells;

  always #10 CLK = ~CLK;

  maze_bitmap_ram #(
    .WORD_W(WORD_W), .ROW_WORDS(ROW_WORDS), .ROWS(ROWS), .CELL_SHIFT(CELL_SHIFT), .ADDR_W(ADDR_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .FRAME_START(FRAME_START), .DrawX(DrawX), .DrawY(DrawY),
    .cell_cur(cell_cur), .cell_up(cell_up), .cell_down(cell_down), .cell_left(cell_left),
    .cell_right(cell_right), .maze_ready(maze_ready)
  );

  assign dut_cells = {cell_right, cell_left, cell_down, cell_up, cell_cur};

  // Reference model: two banks of words, plus the control state seen by software.
  bit [31:0]   m_mem [2][DEPTH];
  bit          m_front, m_pend, m_ready, m_busy, m_cbank;
  int          m_cnt;
  logic [31:0] m_rdata;
  logic [4:0]  m_cells;
  int          n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_front = 0; m_pend = 0; m_ready = 0; m_busy = 0; m_cnt = 0;
    m_rdata = '0; m_cells = '0;
  endtask

  function automatic bit wall(input int cx, input int cy);
    bit [31:0] w;
    if (cx < 0 || cy < 0 || cx >= COLS || cy >= ROWS) return 1'b1;
    w = m_mem[m_front][cy * ROW_WORDS + cx / WORD_W];
    return w[WORD_W - 1 - (cx % WORD_W)];
  endfunction

  function automatic logic [4:0] ref_cells(input int x, input int y);
    int cx, cy;
    cx = x >> CELL_SHIFT;
    cy = y >> CELL_SHIFT;
    if (!m_ready) return 5'h00;
    if (cx >= COLS || cy >= ROWS) return 5'h1F;
    return {wall(cx + 1, cy), wall(cx - 1, cy), wall(cx, cy + 1), wall(cx, cy - 1), wall(cx, cy)};
  endfunction

  function automatic logic [31:0] ref_read(input int a);
    if (a < DEPTH) return m_mem[~m_front][a];
    if (a == DEPTH) return {28'h0, m_ready, m_front, m_busy, m_pend};
    return 32'h0;
  endfunction

  // One clock: apply this cycle's inputs to the model, then advance the DUT.
  task automatic step();
    int a;
    bit wr, ctrl_wr, start, swap, back;
    a       = int'(AVL_ADDR);
    back    = ~m_front;
    wr      = AVL_CS && AVL_WRITE;
    ctrl_wr = wr && (a == DEPTH) && AVL_BYTE_EN[0];
    start   = ctrl_wr && AVL_WRITEDATA[1] && !m_busy;
    swap    = FRAME_START && m_pend && !m_busy && !start;
    m_cells = ref_cells(int'(DrawX), int'(DrawY));
    if (AVL_CS && AVL_READ) m_rdata = ref_read(a);
    if (wr && a < DEPTH && !m_busy)
      for (int b = 0; b < 4; b++)
        if (AVL_BYTE_EN[b]) m_mem[back][a][b*8 +: 8] = AVL_WRITEDATA[b*8 +: 8];
    if (m_busy) begin
      m_mem[m_cbank][m_cnt] = '0;
      if (m_cnt == DEPTH - 1) m_busy = 0;
      else m_cnt++;
    end
    if (start) begin m_busy = 1; m_cnt = 0; m_cbank = back; end
    if (ctrl_wr && AVL_WRITEDATA[0]) m_pend = 1;
    else if (swap) m_pend = 0;
    if (swap) begin m_front = ~m_front; m_ready = 1; end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 10'(a); AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    step();
    AVL_CS = 0; AVL_WRITE = 0;
  endtask

  task automatic rd(input string tag, input int a);
    AVL_CS = 1; AVL_READ = 1; AVL_ADDR = 10'(a);
    step();
    AVL_CS = 0; AVL_READ = 0;
    chk(tag, AVL_READDATA, m_rdata);
  endtask

  task automatic frame();
    FRAME_START = 1;
    step();
    FRAME_START = 0;
  endtask

  task automatic pix(input string tag, input int x, input int y);
    DrawX = 10'(x); DrawY = 10'(y);
    step();
    chk(tag, 32'(dut_cells), 32'(m_cells));
  endtask

  initial begin
    int a;
    logic [31:0] r599, r450;
    RESET = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_CS = 0; AVL_BYTE_EN = '0;
    AVL_ADDR = '0; AVL_WRITEDATA = '0; FRAME_START = 0; DrawX = '0; DrawY = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rdata", AVL_READDATA, 32'h0);
    chk("rst_ready", 32'(maze_ready), 32'h0);
    chk("rst_cells", 32'(dut_cells), 32'h0);
    RESET = 1;

    rd("ctrl_after_reset", DEPTH);
    chk("ctrl_after_reset_const", AVL_READDATA, 32'h0);
    pix("cells_not_ready_a", 100, 200);
    pix("cells_not_ready_b", 0, 0);

    // Wipe bank 1 with the clear engine so every later lookup is defined.
    wr(DEPTH, 32'h2, 4'b0001);
    rd("ctrl_busy", DEPTH);
    idle(DEPTH);
    rd("ctrl_clear_done", DEPTH);

    wr(0, 32'h8000_0000, 4'b1000);
    wr(DEPTH, 32'h1, 4'b0001);
    frame();
    pix("cell_origin", 0, 0);
    chk("cell_origin_const", 32'(dut_cells), 32'h0B);
    rd("ctrl_after_first_swap", DEPTH);
    chk("ctrl_after_first_swap_const", AVL_READDATA, 32'hC);

    wr(DEPTH, 32'h2, 4'b0001);
    idle(DEPTH);
    wr(0, 32'h0000_0001, 4'hF);
    wr(1, 32'h8000_0000, 4'hF);
    wr(DEPTH, 32'h1, 4'b0001);
    frame();
    pix("cell_31", 31 << 2, 0);
    chk("cell_31_const", 32'(dut_cells), 32'h13);
    pix("cell_32", 32 << 2, 0);
    chk("cell_32_const", 32'(dut_cells), 32'h0B);

    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, DEPTH + 30);
      if (a == DEPTH) a = DEPTH + 1;
      wr(a, $urandom, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 10; i++) rd($sformatf("rand_rd_%0d", i), $urandom_range(0, DEPTH + 30));
    wr(DEPTH, 32'h1, 4'b0001);
    frame();
    for (int i = 0; i < 30; i++)
      pix($sformatf("rand_pix_%0d", i), $urandom_range(0, 660), $urandom_range(0, 500));
    pix("corner_br", 639, 479);
    pix("oor_x", 640, 0);
    chk("oor_x_const", 32'(dut_cells), 32'h1F);
    pix("oor_y", 0, 480);

    // Clear plus swap request; the frame pulse mid-clear must not swap.
    wr(DEPTH, 32'h3, 4'b0001);
    idle(8);
    frame();
    rd("ctrl_mid_clear", DEPTH);
    chk("ctrl_mid_clear_busy", 32'(AVL_READDATA[1]), 32'h1);
    wr(5, 32'hDEAD_BEEF, 4'hF);
    pix("pix_mid_clear", $urandom_range(0, 639), $urandom_range(0, 479));
    idle(DEPTH);
    frame();
    rd("ctrl_after_clear_swap", DEPTH);
    for (int i = 0; i < 8; i++) rd($sformatf("old_front_%0d", i), $urandom_range(0, DEPTH - 1));
    rd("old_front_w5", 5);
    for (int i = 0; i < 6; i++)
      pix($sformatf("cleared_pix_%0d", i), $urandom_range(0, 639), $urandom_range(0, 479));
    idle(3);
    chk("rdata_hold", AVL_READDATA, m_rdata);

    // Swap request landing on the same cycle as FRAME_START.
    AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 10'(DEPTH); AVL_WRITEDATA = 32'h1; AVL_BYTE_EN = 4'b0001;
    FRAME_START = 1;
    step();
    AVL_CS = 0; AVL_WRITE = 0; FRAME_START = 0;
    rd("ctrl_coincident", DEPTH);
    chk("ctrl_coincident_front", 32'(AVL_READDATA[2]), 32'h0);
    frame();
    rd("ctrl_coincident_next", DEPTH);

    // Reset in the middle of a clear of bank 1.
    wr(DEPTH, 32'h1, 4'b0001);
    frame();
    r599 = $urandom | 32'h1;
    r450 = $urandom | 32'h1;
    wr(599, r599, 4'hF);
    wr(450, r450, 4'hF);
    wr(0, 32'h1234_5678, 4'hF);
    wr(DEPTH, 32'h2, 4'b0001);
    idle(300);
    RESET = 0;
    #2;
    chk("rst_mid_ready", 32'(maze_ready), 32'h0);
    chk("rst_mid_rdata", AVL_READDATA, 32'h0);
    chk("rst_mid_cells", 32'(dut_cells), 32'h0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1;
    rd("ctrl_after_abort", DEPTH);
    rd("w599_after_abort", 599);
    chk("w599_after_abort_const", AVL_READDATA, r599);
    rd("w450_after_abort", 450);
    rd("w0_after_abort", 0);
    chk("w0_after_abort_const", AVL_READDATA, 32'h0);
    pix("cells_after_abort", 200, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
